// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception arbiter driving CP0 commit, flush and redirect (optional EXC_PERF_CNT_EN)
module exc_ctrl #(
    parameter logic [31:0] EXC_OFFSET = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [6:0]  mem_flags_i,
    input  logic        mem_load_i,
    input  logic        mem_store_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic [31:0] cp0_ebase_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
`ifdef EXC_PERF_CNT_EN
    output logic [31:0] exc_count_o,
`endif
    output logic        mem_kill_o
);

    // Exception codes handed to CP0; zero means no exception.
    localparam logic [31:0] EXC_NONE           = 32'h0000_0000;
    localparam logic [31:0] EXC_INT            = 32'h0000_0001;
    localparam logic [31:0] EXC_INST_ADD_ERR   = 32'h0000_0002;
    localparam logic [31:0] EXC_RI             = 32'h0000_0003;
    localparam logic [31:0] EXC_SYSCALL        = 32'h0000_0004;
    localparam logic [31:0] EXC_BREAK          = 32'h0000_0005;
    localparam logic [31:0] EXC_TRAP           = 32'h0000_0006;
    localparam logic [31:0] EXC_OVF            = 32'h0000_0007;
    localparam logic [31:0] EXC_DATA_ADD_ERR_L = 32'h0000_0008;
    localparam logic [31:0] EXC_DATA_ADD_ERR_S = 32'h0000_0009;
    localparam logic [31:0] EXC_ERET           = 32'h0000_000E;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [4:0] CP0_EBASE  = 5'd15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t state_q;
    state_t state_n;

    logic [31:0] status_f;
    logic [31:0] cause_f;
    logic [31:0] epc_f;
    logic [31:0] ebase_f;
    logic        int_pend;
    logic        mis_align;
    logic        data_ade_l;
    logic        data_ade_s;
    logic [31:0] sel_code;
    logic [31:0] cand;
    logic        has_cand;
    logic        commit;

    // Bits of the forwarded registers that no decision here looks at.
    logic unused_bits;
    assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};

    // Forward the WB-stage CP0 write; software can only write Cause IP[1:0].
    always_comb begin
        status_f = cp0_status_i;
        cause_f  = cp0_cause_i;
        epc_f    = cp0_epc_i;
        ebase_f  = cp0_ebase_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_STATUS: status_f = wb_cp0_data_i;
                CP0_CAUSE:  cause_f[9:8] = wb_cp0_data_i[9:8];
                CP0_EPC:    epc_f = wb_cp0_data_i;
                CP0_EBASE:  ebase_f = wb_cp0_data_i;
                default:    ;
            endcase
        end
    end

    assign int_pend = status_f[0] & ~status_f[1] & (|(cause_f[15:8] & status_f[15:8]));

    // Alignment check: halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        mis_align = 1'b0;
        case (mem_size_i)
            2'd0:    mis_align = 1'b0;
            2'd1:    mis_align = mem_addr_i[0];
            default: mis_align = |mem_addr_i[1:0];
        endcase
    end

    assign data_ade_l = mem_load_i & mis_align;
    assign data_ade_s = mem_store_i & mis_align & ~mem_load_i;

    // Priority select of the exception cause, highest priority first.
    always_comb begin
        sel_code = EXC_NONE;
        if (int_pend)            sel_code = EXC_INT;
        else if (mem_flags_i[6]) sel_code = EXC_INST_ADD_ERR;
        else if (mem_flags_i[5]) sel_code = EXC_RI;
        else if (mem_flags_i[4]) sel_code = EXC_SYSCALL;
        else if (mem_flags_i[3]) sel_code = EXC_BREAK;
        else if (mem_flags_i[2]) sel_code = EXC_TRAP;
        else if (mem_flags_i[1]) sel_code = EXC_OVF;
        else if (data_ade_l)     sel_code = EXC_DATA_ADD_ERR_L;
        else if (data_ade_s)     sel_code = EXC_DATA_ADD_ERR_S;
        else if (mem_flags_i[0]) sel_code = EXC_ERET;
    end

    // Interrupts and faults only attach to a real instruction, never a bubble.
    assign cand     = mem_valid_i ? sel_code : EXC_NONE;
    assign has_cand = (cand != EXC_NONE);
    assign commit   = ~rst & (state_q == ST_IDLE) & has_cand & ~stall_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_n;
    end

    // Next state: after a commit, skip exactly one cycle so the stale MEM instruction cannot commit twice.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (has_cand && !stall_i) state_n = ST_BLANK;
            ST_BLANK: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Outputs: everything zero except in the commit cycle; kill also covers stalled faults.
    always_comb begin
        excepttype_o        = EXC_NONE;
        current_inst_addr_o = 32'h0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = 32'h0;
        flush_o             = 1'b0;
        new_pc_o            = 32'h0;
        mem_kill_o          = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            mem_kill_o = has_cand;
            if (commit) begin
                excepttype_o        = cand;
                current_inst_addr_o = mem_pc_i;
                is_in_delayslot_o   = mem_in_delayslot_i;
                flush_o             = 1'b1;
                new_pc_o            = (cand == EXC_ERET) ? epc_f : (ebase_f + EXC_OFFSET);
                if (cand == EXC_INST_ADD_ERR)
                    bad_addr_o = mem_pc_i;
                else if (cand == EXC_DATA_ADD_ERR_L || cand == EXC_DATA_ADD_ERR_S)
                    bad_addr_o = mem_addr_i;
            end
        end
    end

`ifdef EXC_PERF_CNT_EN
    // Count committed exceptions other than ERET; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            exc_count_o <= 32'h0;
        else if (commit && cand != EXC_ERET)
            exc_count_o <= exc_count_o + 32'h1;
    end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard testbench for exc_ctrl
module tb_exc_ctrl;

    localparam logic [31:0] C_INT   = 32'h01;
    localparam logic [31:0] C_IADE  = 32'h02;
    localparam logic [31:0] C_RI    = 32'h03;
    localparam logic [31:0] C_SYS   = 32'h04;
    localparam logic [31:0] C_ADEL  = 32'h08;
    localparam logic [31:0] C_ADES  = 32'h09;
    localparam logic [31:0] C_ERET  = 32'h0E;
    localparam logic [31:0] VEC     = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [6:0]  mem_flags_i;
    logic        mem_load_i;
    logic        mem_store_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic        stall_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic [31:0] cp0_ebase_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        mem_kill_o;
`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_count_o;
`endif

    exc_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_flags_i         (mem_flags_i),
        .mem_load_i          (mem_load_i),
        .mem_store_i         (mem_store_i),
        .mem_size_i          (mem_size_i),
        .mem_addr_i          (mem_addr_i),
        .stall_i             (stall_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .cp0_ebase_i         (cp0_ebase_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
`ifdef EXC_PERF_CNT_EN
        .exc_count_o         (exc_count_o),
`endif
        .mem_kill_o          (mem_kill_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] etype;
        logic [31:0] cur;
        logic        ds;
        logic [31:0] bad;
        logic        flush;
        logic [31:0] npc;
        logic        kill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] et, input logic [31:0] cur,
                                input logic ds, input logic [31:0] bad, input logic fl,
                                input logic [31:0] npc, input logic kill);
        exp_t e;
        e.tag = tag; e.etype = et; e.cur = cur; e.ds = ds; e.bad = bad;
        e.flush = fl; e.npc = npc; e.kill = kill;
        return e;
    endfunction

    function automatic exp_t quiet(input string tag);
        return mk(tag, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endfunction

    // Inputs are already driven; push expectation, sample mid-cycle, compare, then advance.
    task automatic step(input exp_t e);
        exp_t g;
        sb.push_back(e);
        #3;
        g = sb.pop_front();
        chk({g.tag, ".type"},  excepttype_o,               g.etype);
        chk({g.tag, ".pc"},    current_inst_addr_o,        g.cur);
        chk({g.tag, ".ds"},    {31'h0, is_in_delayslot_o}, {31'h0, g.ds});
        chk({g.tag, ".bad"},   bad_addr_o,                 g.bad);
        chk({g.tag, ".flush"}, {31'h0, flush_o},           {31'h0, g.flush});
        chk({g.tag, ".npc"},   new_pc_o,                   g.npc);
        chk({g.tag, ".kill"},  {31'h0, mem_kill_o},        {31'h0, g.kill});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0;
        mem_flags_i = 7'h0; mem_load_i = 1'b0; mem_store_i = 1'b0;
        mem_size_i = 2'd0; mem_addr_i = 32'h0; stall_i = 1'b0;
        wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    endtask

    task automatic inst(input logic [31:0] pc, input logic [6:0] flags);
        mem_valid_i = 1'b1; mem_pc_i = pc; mem_flags_i = flags;
    endtask

    initial begin
        rst = 1'b1;
        clear_mem();
        cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
        cp0_ebase_i = 32'h8000_0000;
        @(posedge clk);
        #1;
        // Reset with a faulting instruction present: nothing escapes.
        inst(32'h8000_0000, 7'b0010000);
        step(quiet("rst0"));
        step(quiet("rst1"));
        rst = 1'b0;

        // Misaligned store, then the stale copy must be ignored.
        clear_mem();
        inst(32'h8000_0100, 7'h0);
        mem_store_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h8000_0102;
        step(mk("ades", C_ADES, 32'h8000_0100, 1'b0, 32'h8000_0102, 1'b1, VEC, 1'b1));
        step(quiet("ades_blank"));
        clear_mem();
        step(quiet("bubble0"));

        // ERET with EPC forwarded from WB.
        inst(32'h8000_0200, 7'b0000001);
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'hBFC0_0400;
        step(mk("eret", C_ERET, 32'h8000_0200, 1'b0, 32'h0, 1'b1, 32'hBFC0_0400, 1'b1));
        clear_mem();
        step(quiet("eret_blank"));

        // Priority with delay slot.
        inst(32'h8000_0010, 7'b0110010);
        mem_in_delayslot_i = 1'b1;
        step(mk("prio", C_RI, 32'h8000_0010, 1'b1, 32'h0, 1'b1, VEC, 1'b1));
        clear_mem();
        step(quiet("prio_blank"));

        // Interrupt gating: bubble ignored, valid add takes it, BLANK defers it.
        cp0_status_i = 32'h0000_8001; cp0_cause_i = 32'h0000_8000;
        step(quiet("int_bubble"));
        inst(32'h8000_0020, 7'h0);
        step(mk("int", C_INT, 32'h8000_0020, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        inst(32'h8000_0024, 7'h0);
        step(quiet("int_blank"));
        step(mk("int_again", C_INT, 32'h8000_0024, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        clear_mem();
        step(quiet("int_blank2"));
        cp0_status_i = 32'h0000_8003;
        inst(32'h8000_0028, 7'h0);
        step(quiet("int_exl"));

        // Interrupt enabled only through forwarded Cause IP0 write.
        cp0_status_i = 32'h0000_0101; cp0_cause_i = 32'h0;
        step(quiet("swint_off"));
        wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0100;
        step(mk("swint", C_INT, 32'h8000_0028, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        clear_mem();
        cp0_status_i = 32'h0;
        step(quiet("swint_blank"));

        // Stall hold: kill asserted, no commit until stall drops.
        inst(32'h8000_0030, 7'b0010000);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) step(mk("stall", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        stall_i = 1'b0;
        step(mk("stall_go", C_SYS, 32'h8000_0030, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        clear_mem();
        step(quiet("stall_blank"));

        // Load alignment corners and instruction address error priority.
        inst(32'h8000_0040, 7'h0);
        mem_load_i = 1'b1; mem_size_i = 2'd1; mem_addr_i = 32'h1000_0003;
        step(mk("adel", C_ADEL, 32'h8000_0040, 1'b0, 32'h1000_0003, 1'b1, VEC, 1'b1));
        mem_size_i = 2'd2; mem_addr_i = 32'h1000_0004;
        step(quiet("adel_blank"));
        step(quiet("word_ok"));
        mem_size_i = 2'd0; mem_addr_i = 32'h1000_0001;
        step(quiet("byte_ok"));
        mem_size_i = 2'd3; mem_addr_i = 32'h1000_0002; mem_flags_i = 7'b1000000;
        step(mk("iade", C_IADE, 32'h8000_0040, 1'b0, 32'h8000_0040, 1'b1, VEC, 1'b1));
        clear_mem();
        step(quiet("iade_blank"));

        // Reset during BLANK, then normal commit resumes.
        inst(32'h8000_0050, 7'b0010000);
        step(mk("pre_rst", C_SYS, 32'h8000_0050, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        rst = 1'b1;
        step(quiet("mid_rst"));
        rst = 1'b0;
        step(mk("post_rst", C_SYS, 32'h8000_0050, 1'b0, 32'h0, 1'b1, VEC, 1'b1));
        clear_mem();
`ifdef EXC_PERF_CNT_EN
        chk("count", exc_count_o, 32'h1);
`endif
        step(quiet("post_blank"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
